// File: rtl/debug_ctrl_pkg.sv
// rtl/debug_ctrl_pkg.sv - shared encodings and defaults for the debug controller
package debug_ctrl_pkg;

  localparam int PC_WIDTH_DEF   = 10;
  localparam int STEP_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    OP_RUN   = 2'b00,
    OP_HALT  = 2'b01,
    OP_STEP  = 2'b10,
    OP_SETBP = 2'b11
  } cmd_op_e;

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_HALT_LOAD = 3'd1;
  localparam logic [2:0] ST_HALT_ARM  = 3'd2;
  localparam logic [2:0] ST_HALTED    = 3'd3;
  localparam logic [2:0] ST_STEP_LOAD = 3'd4;
  localparam logic [2:0] ST_STEPPING  = 3'd5;

endpackage

// File: rtl/debug_ctrl_if.sv
// rtl/debug_ctrl_if.sv - host command channel, target pc and clock-gater control bundle
interface debug_ctrl_if
  import debug_ctrl_pkg::*;
#(
  parameter int PC_WIDTH   = PC_WIDTH_DEF,
  parameter int STEP_WIDTH = STEP_WIDTH_DEF
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [PC_WIDTH-1:0]   cmd_arg;
  logic [PC_WIDTH-1:0]   pc;
  logic                  debug_en;
  logic                  stepinto_en;
  logic [STEP_WIDTH-1:0] stepvalue;
  logic                  halted;
  logic                  step_done;
  logic                  bp_hit;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, pc,
    input  cmd_ready, debug_en, stepinto_en, stepvalue, halted, step_done, bp_hit
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, pc,
    output cmd_ready, debug_en, stepinto_en, stepvalue, halted, step_done, bp_hit
  );

endinterface

// File: rtl/debug_ctrl.sv
// rtl/debug_ctrl.sv - halt/step/breakpoint sequencer driving a clock-gating debugger
module debug_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int PC_WIDTH   = PC_WIDTH_DEF,
  parameter int STEP_WIDTH = STEP_WIDTH_DEF
) (
  input  logic          clk_in,
  input  logic          rst_n,
  debug_ctrl_if.slave   bus
);

  logic [2:0]            r_state;
  logic                  r_bp_valid;
  logic [PC_WIDTH-1:0]   r_bp_addr;
  logic [STEP_WIDTH-1:0] r_step_n;
  logic [STEP_WIDTH:0]   r_step_cnt;
  logic                  r_debug_en;
  logic                  r_stepinto_en;
  logic [STEP_WIDTH-1:0] r_stepvalue;
  logic                  r_halted;
  logic                  r_step_done;
  logic                  r_bp_hit;

  logic [2:0]            w_next_state;
  logic                  w_bp_match;
  logic                  w_cmd_ready;
  logic                  w_accept;
  logic                  w_setbp;
  logic [STEP_WIDTH-1:0] w_arg_n;
  logic [STEP_WIDTH-1:0] w_step_n;
  logic                  w_step_done_nxt;
  logic                  w_bp_hit_nxt;
  logic                  w_debug_en;
  logic                  w_stepinto_en;
  logic [STEP_WIDTH-1:0] w_stepvalue;

  // A breakpoint match steals the cycle from the host, which must retry its command.
  assign w_bp_match  = (r_state == ST_RUN) && r_bp_valid && (bus.pc == r_bp_addr);
  assign w_cmd_ready = (r_state == ST_HALTED) || ((r_state == ST_RUN) && !w_bp_match);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_setbp     = w_accept && (bus.cmd_op == OP_SETBP);
  assign w_arg_n     = bus.cmd_arg[STEP_WIDTH-1:0];

  always_comb begin
    w_next_state    = r_state;
    w_step_done_nxt = 1'b0;
    w_bp_hit_nxt    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_bp_match) begin
          w_next_state = ST_HALT_LOAD;
          w_bp_hit_nxt = 1'b1;
        end else if (w_accept && (bus.cmd_op == OP_HALT)) begin
          w_next_state = ST_HALT_LOAD;
        end
      end
      ST_HALT_LOAD: w_next_state = ST_HALT_ARM;
      ST_HALT_ARM:  w_next_state = ST_HALTED;
      ST_HALTED: begin
        if (w_accept && (bus.cmd_op == OP_RUN)) begin
          w_next_state = ST_RUN;
        end else if (w_accept && (bus.cmd_op == OP_STEP)) begin
          if (w_arg_n == '0) w_step_done_nxt = 1'b1;
          else               w_next_state    = ST_STEP_LOAD;
        end
      end
      ST_STEP_LOAD: w_next_state = ST_STEPPING;
      ST_STEPPING: begin
        if (r_step_cnt == '0) begin
          w_next_state    = ST_HALTED;
          w_step_done_nxt = 1'b1;
        end
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // Gater controls are decoded from the next state so every output leaves a flop.
  assign w_step_n      = ((r_state == ST_HALTED) && (w_next_state == ST_STEP_LOAD)) ? w_arg_n : r_step_n;
  assign w_debug_en    = (w_next_state == ST_HALTED) || (w_next_state == ST_STEP_LOAD) ||
                         (w_next_state == ST_STEPPING);
  assign w_stepinto_en = (w_next_state == ST_HALT_ARM) || (w_next_state == ST_HALTED) ||
                         (w_next_state == ST_STEPPING);
  assign w_stepvalue   = ((w_next_state == ST_STEP_LOAD) || (w_next_state == ST_STEPPING)) ?
                         w_step_n : '0;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_bp_valid    <= 1'b0;
      r_bp_addr     <= '0;
      r_step_n      <= '0;
      r_step_cnt    <= '0;
      r_debug_en    <= 1'b0;
      r_stepinto_en <= 1'b0;
      r_stepvalue   <= '0;
      r_halted      <= 1'b0;
      r_step_done   <= 1'b0;
      r_bp_hit      <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_step_n      <= w_step_n;
      r_debug_en    <= w_debug_en;
      r_stepinto_en <= w_stepinto_en;
      r_stepvalue   <= w_stepvalue;
      r_halted      <= (w_next_state == ST_HALTED);
      r_step_done   <= w_step_done_nxt;
      r_bp_hit      <= w_bp_hit_nxt;
      if (w_setbp) begin
        r_bp_addr  <= bus.cmd_arg;
        r_bp_valid <= ~&bus.cmd_arg;
      end
      // Counting N down to zero keeps STEPPING for N+1 cycles, giving the gater N edges.
      if (r_state == ST_STEP_LOAD) begin
        r_step_cnt <= {1'b0, r_step_n};
      end else if ((r_state == ST_STEPPING) && (r_step_cnt != '0)) begin
        r_step_cnt <= r_step_cnt - (STEP_WIDTH+1)'(1);
      end
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.debug_en    = r_debug_en;
  assign bus.stepinto_en = r_stepinto_en;
  assign bus.stepvalue   = r_stepvalue;
  assign bus.halted      = r_halted;
  assign bus.step_done   = r_step_done;
  assign bus.bp_hit      = r_bp_hit;

endmodule

// File: tb/tb_debug_ctrl.sv
// tb/tb_debug_ctrl.sv - self-checking bench for debug_ctrl with behavioural model and gater model
module tb_debug_ctrl;
  import debug_ctrl_pkg::*;

  localparam int PW = 10;
  localparam int SW = 3;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  debug_ctrl_if #(.PC_WIDTH(PW), .STEP_WIDTH(SW)) bus ();

  debug_ctrl #(.PC_WIDTH(PW), .STEP_WIDTH(SW)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: halted mode, pending halt delay, pending step load, remaining step cycles.
  bit m_halted_mode;
  int m_halt_wait;
  bit m_step_load;
  int m_step_cycles;
  int m_n;
  bit m_bp_valid;
  int m_bp_addr;
  bit m_bp_hit;
  bit m_step_done;

  function automatic bit m_running();
    return !m_halted_mode && (m_halt_wait == 0);
  endfunction

  function automatic bit m_idle_halted();
    return m_halted_mode && !m_step_load && (m_step_cycles == 0);
  endfunction

  function automatic bit m_match();
    return m_running() && m_bp_valid && (int'(bus.pc) == m_bp_addr);
  endfunction

  function automatic bit m_ready();
    return m_idle_halted() || (m_running() && !m_match());
  endfunction

  always @(posedge clk_in or negedge rst_n) begin : model
    bit acc;
    int op;
    int arg;
    if (!rst_n) begin
      m_halted_mode = 0; m_halt_wait = 0; m_step_load = 0; m_step_cycles = 0;
      m_n = 0; m_bp_valid = 0; m_bp_addr = 0; m_bp_hit = 0; m_step_done = 0;
    end else begin
      acc = bus.cmd_valid && m_ready();
      op  = int'(bus.cmd_op);
      arg = int'(bus.cmd_arg);
      m_bp_hit = 0;
      m_step_done = 0;
      if (m_running()) begin
        if (m_match()) begin
          m_halt_wait = 2;
          m_bp_hit = 1;
        end else if (acc && op == 1) begin
          m_halt_wait = 2;
        end else if (acc && op == 3) begin
          m_bp_addr = arg;
          m_bp_valid = (arg != (1 << PW) - 1);
        end
      end else if (m_halt_wait > 0) begin
        m_halt_wait--;
        if (m_halt_wait == 0) m_halted_mode = 1;
      end else if (m_step_load) begin
        m_step_load = 0;
        m_step_cycles = m_n + 1;
      end else if (m_step_cycles > 0) begin
        m_step_cycles--;
        if (m_step_cycles == 0) m_step_done = 1;
      end else if (acc) begin
        if (op == 0) begin
          m_halted_mode = 0;
        end else if (op == 2) begin
          if (arg % (1 << SW) == 0) begin
            m_step_done = 1;
          end else begin
            m_n = arg % (1 << SW);
            m_step_load = 1;
          end
        end else if (op == 3) begin
          m_bp_addr = arg;
          m_bp_valid = (arg != (1 << PW) - 1);
        end
      end
    end
  end

  // Clock-gater model: counts gated target edges while gating is enabled.
  int g_cnt = 0;
  int g_edges = 0;
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      g_cnt = 0;
    end else begin
      if (bus.debug_en && bus.stepinto_en && g_cnt > 0) g_edges++;
      if (!bus.stepinto_en) g_cnt = int'(bus.stepvalue);
      else if (g_cnt > 0) g_cnt--;
    end
  end

  int sd_cnt = 0;
  int bh_cnt = 0;
  int stepping_cyc = 0;

  always @(negedge clk_in) begin
    if (rst_n) begin
      check("cmd_ready",   bus.cmd_ready,   m_ready());
      check("debug_en",    bus.debug_en,    m_halted_mode);
      check("stepinto_en", bus.stepinto_en, (m_halt_wait == 1) || (m_halted_mode && !m_step_load));
      check("stepvalue",   bus.stepvalue,   (m_step_load || m_step_cycles > 0) ? m_n : 0);
      check("halted",      bus.halted,      m_idle_halted());
      check("step_done",   bus.step_done,   m_step_done);
      check("bp_hit",      bus.bp_hit,      m_bp_hit);
      if (bus.step_done) sd_cnt++;
      if (bus.bp_hit) bh_cnt++;
      if (bus.debug_en && bus.stepinto_en && bus.stepvalue != '0) stepping_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input int arg);
    bit acc;
    acc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg[PW-1:0];
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk_in);
      acc = bus.cmd_ready;
      @(posedge clk_in);
      #1;
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accepted", acc, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_debug_en"},    bus.debug_en,    0);
    check({tag, "_stepinto_en"}, bus.stepinto_en, 0);
    check({tag, "_stepvalue"},   bus.stepvalue,   0);
    check({tag, "_halted"},      bus.halted,      0);
    check({tag, "_step_done"},   bus.step_done,   0);
    check({tag, "_bp_hit"},      bus.bp_hit,      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int sd0, e0, s0, bh0;
    int pcs[5];
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_arg   = '0;
    bus.pc        = '0;

    #12;
    check_all_zero("reset");
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    tick();
    check("run_ready", bus.cmd_ready, 1);

    // HALT: HALT_LOAD, HALT_ARM, halted on the third cycle
    send(2'b01, 0);
    check("halt_c1_halted", bus.halted, 0);
    check("halt_c1_debug_en", bus.debug_en, 0);
    tick();
    check("halt_c2_stepinto", bus.stepinto_en, 1);
    check("halt_c2_debug_en", bus.debug_en, 0);
    tick();
    check("halt_c3_halted", bus.halted, 1);
    check("halt_c3_debug_en", bus.debug_en, 1);

    // STEP N=5
    sd0 = sd_cnt; e0 = g_edges; s0 = stepping_cyc;
    send(2'b10, 5);
    check("step5_load_stepinto", bus.stepinto_en, 0);
    check("step5_load_value", bus.stepvalue, 5);
    repeat (10) tick();
    check("step5_gated_edges", g_edges - e0, 5);
    check("step5_stepping_cycles", stepping_cyc - s0, 6);
    check("step5_done_pulses", sd_cnt - sd0, 1);
    check("step5_halted", bus.halted, 1);

    // STEP N=0
    sd0 = sd_cnt; e0 = g_edges;
    send(2'b10, 0);
    check("step0_done_next", bus.step_done, 1);
    repeat (3) tick();
    check("step0_done_pulses", sd_cnt - sd0, 1);
    check("step0_gated_edges", g_edges - e0, 0);
    check("step0_halted", bus.halted, 1);

    // RUN, then STEP in RUN is ignored
    send(2'b00, 0);
    tick();
    check("run_halted", bus.halted, 0);
    check("run_debug_en", bus.debug_en, 0);
    send(2'b10, 3);
    repeat (3) tick();
    check("run_step_halted", bus.halted, 0);
    check("run_step_stepinto", bus.stepinto_en, 0);

    // Breakpoint at 0x040 with pc ramp
    bus.pc = 10'h03E;
    send(2'b11, 'h040);
    bh0 = bh_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.pc = 10'h03E + PW'(i);
      @(negedge clk_in);
      if (i == 2) check("bp_match_ready", bus.cmd_ready, 0);
      if (i < 2)  check("bp_pre_ready", bus.cmd_ready, 1);
      @(posedge clk_in);
      #1;
      if (i == 2) check("bp_hit_pulse", bus.bp_hit, 1);
      if (i == 3) check("bp_hit_single", bus.bp_hit, 0);
    end
    tick();
    check("bp_halted", bus.halted, 1);
    check("bp_hit_count", bh_cnt - bh0, 1);

    // Reset during STEPPING cycle 3 of N=7
    sd0 = sd_cnt;
    send(2'b10, 7);
    repeat (3) tick();
    check("rst_pre_stepvalue", bus.stepvalue, 7);
    check("rst_pre_stepinto", bus.stepinto_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("async_rst_ready", bus.cmd_ready, 1);
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    repeat (12) tick();
    check("rst_no_step_done", sd_cnt - sd0, 0);
    check("rst_running", bus.halted, 0);

    // All-ones SETBP disables breakpoints
    send(2'b11, 'h3FF);
    bh0 = bh_cnt;
    pcs = '{'h3FD, 'h3FE, 'h3FF, 'h000, 'h040};
    for (int i = 0; i < 5; i++) begin
      bus.pc = pcs[i][PW-1:0];
      tick();
    end
    tick();
    check("bpclr_no_hit", bh_cnt - bh0, 0);
    check("bpclr_halted", bus.halted, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 10, width of program-counter and breakpoint address.
REQ-002 Parameter STEP_WIDTH, default 3, width of step count.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at a rising edge.
REQ-007 cmd_op  input  2  00 RUN, 01 HALT, 10 STEP, 11 SETBP.
REQ-008 cmd_arg  input  PC_WIDTH  STEP: count in low STEP_WIDTH bits; SETBP: breakpoint address.
REQ-009 pc  input  PC_WIDTH  target core program counter.
REQ-010 debug_en  output  1  to clock gater: gating enabled.
REQ-011 stepinto_en  output  1  to clock gater: 0 loads count, 1 counts down.
REQ-012 stepvalue  output  STEP_WIDTH  to clock gater: count loaded while stepinto_en=0.
REQ-013 halted  output  1  high only in state HALTED.
REQ-014 step_done  output  1  one-cycle pulse at step completion.
REQ-015 bp_hit  output  1  one-cycle pulse when a breakpoint triggers a halt.

Function
REQ-016 FSM states SHALL be RUN, HALT_LOAD, HALT_ARM, HALTED, STEP_LOAD, STEPPING.
REQ-017 Outputs per state SHALL be (debug_en, stepinto_en, stepvalue): RUN (0,0,0); HALT_LOAD (0,0,0); HALT_ARM (0,1,0); HALTED (1,1,0); STEP_LOAD (1,0,N); STEPPING (1,1,N).
REQ-018 All outputs SHALL be registered; no output depends combinationally on inputs except cmd_ready.
REQ-019 cmd_ready SHALL be high in HALTED, and in RUN only when no breakpoint match this cycle; low in all other states.
REQ-020 RUN: accepted HALT SHALL go to HALT_LOAD; RUN and STEP SHALL be accepted and ignored.
REQ-021 Breakpoint match = bp_valid & (pc == bp_addr), evaluated only in RUN; match SHALL go to HALT_LOAD and pulse bp_hit in the following cycle.
REQ-022 HALT_LOAD SHALL last 1 cycle then HALT_ARM; HALT_ARM 1 cycle then HALTED (halt latency 2 cycles after acceptance/match).
REQ-023 HALTED: accepted RUN SHALL go to RUN next cycle; HALT ignored; STEP with N=0 SHALL stay HALTED and pulse step_done next cycle.
REQ-024 HALTED: STEP with N>0 SHALL latch N, go to STEP_LOAD for 1 cycle, then STEPPING for exactly N+1 cycles (internal down-counter, STEP_WIDTH+1 bits), then HALTED with step_done pulsed on the first HALTED cycle.
REQ-025 Target gated clock SHALL therefore run exactly N cycles per STEP; breakpoints SHALL be ignored outside RUN.
REQ-026 SETBP, accepted in RUN or HALTED, SHALL set bp_addr=cmd_arg, bp_valid=1, no state change; cmd_arg all-ones SHALL set bp_valid=0.
REQ-027 Breakpoint match and cmd_valid in the same RUN cycle: breakpoint wins, command not accepted (host retries).
REQ-028 Breakpoint at pc already equal on RUN re-entry SHALL re-trigger; host must move or clear bp before RUN.

Reset
REQ-029 rst_n low SHALL immediately force state RUN, debug_en=0, stepinto_en=0, stepvalue=0, halted=0, step_done=0, bp_hit=0, bp_valid=0, bp_addr=0, step counter=0.
REQ-030 Reset mid-STEPPING or mid-halt SHALL abandon the operation with no step_done or bp_hit pulse.
REQ-031 Reset state SHALL leave gater ungated so the target runs after reset.

Structure
REQ-032 Shared package SHALL hold cmd_op encodings, FSM state encoding, PC_WIDTH/STEP_WIDTH defaults.
REQ-033 Single flat module; no sub-module; intended to drive the existing clock-gating debugger port-for-port.

Verification
REQ-034 Reset then HALT in RUN -> HALT_LOAD, HALT_ARM, halted=1 at cycle 3; debug_en=1 only from HALTED.
REQ-035 HALTED, STEP N=5 -> STEP_LOAD 1 cycle, stepinto_en=1 for 6 cycles, stepvalue=5, step_done pulse once; with gater model, exactly 5 gated edges.
REQ-036 SETBP 0x040, RUN, pc ramps 0x03E..0x041 -> bp_hit pulse after pc=0x040, halted=1 two cycles later, cmd_ready=0 on the match cycle.
REQ-037 STEP N=0 in HALTED -> step_done next cycle, zero gated edges; STEP in RUN -> no state change.
REQ-038 rst_n low during STEPPING cycle 3 of N=7 -> all outputs reset asynchronously, no step_done.
REQ-039 SETBP 0x3FF then RUN past any pc -> bp_hit never asserted.
